// File: rtl/mem_wb_pkg.sv
// Shared constants and stage-control decode for the MEM/WB pipeline register.
package mem_wb_pkg;

  localparam int NOP_REG_ADDR = 0;
  localparam int ZERO_WORD    = 0;

  typedef enum logic [1:0] {
    CAPTURE,
    BUBBLE,
    HOLD,
    ILLEGAL
  } stage_ctrl_e;

  // Flush beats any stall; a stalled WB with a running MEM would drop an instruction.
  function automatic stage_ctrl_e decode_ctrl(input logic flush,
                                              input logic stall_mem,
                                              input logic stall_wb);
    if (flush)                       return BUBBLE;
    else if (stall_mem && stall_wb)  return HOLD;
    else if (stall_mem)              return BUBBLE;
    else if (stall_wb)               return ILLEGAL;
    else                             return CAPTURE;
  endfunction

endpackage

// File: rtl/mem_wb_lane.sv
// One lane of the MEM/WB register: valid, write enable, destination and data.
module mem_wb_lane
  import mem_wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  stage_ctrl_e       ctrl,
  input  logic              kill,
  input  logic              mem_valid,
  input  logic              mem_wreg,
  input  logic [ADDR_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              wb_valid,
  output logic              wb_wreg,
  output logic [ADDR_W-1:0] wb_wd,
  output logic [DATA_W-1:0] wb_wdata
);

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_wreg  <= 1'b0;
      wb_wd    <= ADDR_W'(NOP_REG_ADDR);
      wb_wdata <= DATA_W'(ZERO_WORD);
    end else begin
      case (ctrl)
        CAPTURE: begin
          wb_valid <= mem_valid;
          wb_wreg  <= mem_valid & mem_wreg & ~kill;
          wb_wd    <= mem_valid ? mem_wd : ADDR_W'(NOP_REG_ADDR);
          wb_wdata <= mem_valid ? mem_wdata : DATA_W'(ZERO_WORD);
        end
        BUBBLE: begin
          wb_valid <= 1'b0;
          wb_wreg  <= 1'b0;
          wb_wd    <= ADDR_W'(NOP_REG_ADDR);
          wb_wdata <= DATA_W'(ZERO_WORD);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: per-lane RF writes with youngest-writer-wins conflict
// resolution, HI/LO and LLbit updates, retired-instruction counter and control error flag.
module mem_wb_stage
  import mem_wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int LANES  = 2,
  parameter int CNT_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall_mem,
  input  logic                     stall_wb,
  input  logic                     flush,
  input  logic [LANES-1:0]         mem_valid,
  input  logic [LANES-1:0]         mem_wreg,
  input  logic [LANES*ADDR_W-1:0]  mem_wd,
  input  logic [LANES*DATA_W-1:0]  mem_wdata,
  input  logic                     mem_whilo,
  input  logic [DATA_W-1:0]        mem_hi,
  input  logic [DATA_W-1:0]        mem_lo,
  input  logic                     mem_llbit_we,
  input  logic                     mem_llbit_value,
  output logic [LANES-1:0]         wb_valid,
  output logic [LANES-1:0]         wb_wreg,
  output logic [LANES*ADDR_W-1:0]  wb_wd,
  output logic [LANES*DATA_W-1:0]  wb_wdata,
  output logic                     wb_whilo,
  output logic [DATA_W-1:0]        wb_hi,
  output logic [DATA_W-1:0]        wb_lo,
  output logic                     wb_llbit_we,
  output logic                     wb_llbit_value,
  output logic [CNT_W-1:0]         retire_cnt,
  output logic                     ctrl_err
);

  stage_ctrl_e      ctrl;
  logic [LANES-1:0] killed;
  logic [CNT_W-1:0] lane_cnt;
  logic             any_valid;

  assign ctrl      = decode_ctrl(flush, stall_mem, stall_wb);
  assign any_valid = |mem_valid;

  // An older lane is killed when any younger writer targets the same register.
  always_comb begin
    killed = '0;
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (mem_valid[j] && mem_wreg[j] &&
            (mem_wd[j*ADDR_W +: ADDR_W] == mem_wd[i*ADDR_W +: ADDR_W]))
          killed[i] = 1'b1;
      end
    end
  end

  always_comb begin
    lane_cnt = '0;
    for (int i = 0; i < LANES; i++)
      lane_cnt = lane_cnt + CNT_W'(mem_valid[i]);
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mem_wb_lane #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .ctrl     (ctrl),
      .kill     (killed[g]),
      .mem_valid(mem_valid[g]),
      .mem_wreg (mem_wreg[g]),
      .mem_wd   (mem_wd[g*ADDR_W +: ADDR_W]),
      .mem_wdata(mem_wdata[g*DATA_W +: DATA_W]),
      .wb_valid (wb_valid[g]),
      .wb_wreg  (wb_wreg[g]),
      .wb_wd    (wb_wd[g*ADDR_W +: ADDR_W]),
      .wb_wdata (wb_wdata[g*DATA_W +: DATA_W])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_whilo       <= 1'b0;
      wb_hi          <= DATA_W'(ZERO_WORD);
      wb_lo          <= DATA_W'(ZERO_WORD);
      wb_llbit_we    <= 1'b0;
      wb_llbit_value <= 1'b0;
      retire_cnt     <= '0;
      ctrl_err       <= 1'b0;
    end else begin
      case (ctrl)
        CAPTURE: begin
          wb_whilo       <= mem_whilo & any_valid;
          wb_hi          <= mem_hi;
          wb_lo          <= mem_lo;
          wb_llbit_we    <= mem_llbit_we & any_valid;
          wb_llbit_value <= mem_llbit_value;
          retire_cnt     <= retire_cnt + lane_cnt;
        end
        BUBBLE: begin
          wb_whilo       <= 1'b0;
          wb_hi          <= DATA_W'(ZERO_WORD);
          wb_lo          <= DATA_W'(ZERO_WORD);
          wb_llbit_we    <= 1'b0;
          wb_llbit_value <= 1'b0;
        end
        ILLEGAL: ctrl_err <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed vector table, counter-wrap sequence
// on a 4-bit-counter instance, then randomized traffic against a behavioural model.
module tb_mem_wb_stage;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NL = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, stall_mem, stall_wb, flush;
  logic [NL-1:0] mem_valid, mem_wreg;
  logic [NL*AW-1:0] mem_wd;
  logic [NL*DW-1:0] mem_wdata;
  logic          mem_whilo, mem_llbit_we, mem_llbit_value;
  logic [DW-1:0] mem_hi, mem_lo;

  logic [NL-1:0] wb_valid, wb_wreg;
  logic [NL*AW-1:0] wb_wd;
  logic [NL*DW-1:0] wb_wdata;
  logic          wb_whilo, wb_llbit_we, wb_llbit_value, ctrl_err;
  logic [DW-1:0] wb_hi, wb_lo;
  logic [31:0]   retire_cnt;

  logic [NL-1:0] w_valid, w_wreg;
  logic [NL*AW-1:0] w_wd;
  logic [NL*DW-1:0] w_wdata;
  logic          w_whilo, w_llbit_we, w_llbit_value, w_ctrl_err;
  logic [DW-1:0] w_hi, w_lo;
  logic [3:0]    w_retire_cnt;

  mem_wb_stage #(.DATA_W(DW), .ADDR_W(AW), .LANES(NL), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .stall_mem(stall_mem), .stall_wb(stall_wb), .flush(flush),
    .mem_valid(mem_valid), .mem_wreg(mem_wreg), .mem_wd(mem_wd), .mem_wdata(mem_wdata),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .mem_llbit_we(mem_llbit_we), .mem_llbit_value(mem_llbit_value),
    .wb_valid(wb_valid), .wb_wreg(wb_wreg), .wb_wd(wb_wd), .wb_wdata(wb_wdata),
    .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
    .wb_llbit_we(wb_llbit_we), .wb_llbit_value(wb_llbit_value),
    .retire_cnt(retire_cnt), .ctrl_err(ctrl_err)
  );

  mem_wb_stage #(.DATA_W(DW), .ADDR_W(AW), .LANES(NL), .CNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .stall_mem(stall_mem), .stall_wb(stall_wb), .flush(flush),
    .mem_valid(mem_valid), .mem_wreg(mem_wreg), .mem_wd(mem_wd), .mem_wdata(mem_wdata),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .mem_llbit_we(mem_llbit_we), .mem_llbit_value(mem_llbit_value),
    .wb_valid(w_valid), .wb_wreg(w_wreg), .wb_wd(w_wd), .wb_wdata(w_wdata),
    .wb_whilo(w_whilo), .wb_hi(w_hi), .wb_lo(w_lo),
    .wb_llbit_we(w_llbit_we), .wb_llbit_value(w_llbit_value),
    .retire_cnt(w_retire_cnt), .ctrl_err(w_ctrl_err)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural reference state
  logic [NL-1:0] m_valid, m_wreg;
  logic [AW-1:0] m_wd [NL];
  logic [DW-1:0] m_wdata [NL];
  logic          m_whilo, m_llwe, m_llv, m_err;
  logic [DW-1:0] m_hi, m_lo;
  int unsigned   m_cnt;

  task automatic model_clear_stage();
    m_valid = '0; m_wreg = '0; m_whilo = 0; m_llwe = 0; m_llv = 0;
    m_hi = '0; m_lo = '0;
    for (int i = 0; i < NL; i++) begin m_wd[i] = '0; m_wdata[i] = '0; end
  endtask

  // Evaluate what one rising edge should do with the inputs currently applied.
  task automatic model_step();
    logic [31:0] claimed;
    if (rst) begin
      model_clear_stage(); m_cnt = 0; m_err = 0;
    end else if (flush || (stall_mem && !stall_wb)) begin
      model_clear_stage();
    end else if (stall_mem && stall_wb) begin
    end else if (stall_wb) begin
      m_err = 1;
    end else begin
      claimed = '0;
      // Walk youngest to oldest; the first writer to claim an address keeps it.
      for (int i = NL - 1; i >= 0; i--) begin
        logic [AW-1:0] a;
        a = mem_wd[i*AW +: AW];
        m_valid[i] = mem_valid[i];
        m_wd[i]    = mem_valid[i] ? a : '0;
        m_wdata[i] = mem_valid[i] ? mem_wdata[i*DW +: DW] : '0;
        m_wreg[i]  = 0;
        if (mem_valid[i] && mem_wreg[i]) begin
          m_wreg[i] = !claimed[a];
          claimed[a] = 1;
        end
        m_cnt += mem_valid[i] ? 1 : 0;
      end
      m_whilo = mem_whilo && (mem_valid != 0);
      m_llwe  = mem_llbit_we && (mem_valid != 0);
      m_hi = mem_hi; m_lo = mem_lo; m_llv = mem_llbit_value;
    end
  endtask

  task automatic model_compare();
    for (int i = 0; i < NL; i++) begin
      check($sformatf("m_valid%0d", i), wb_valid[i], m_valid[i]);
      check($sformatf("m_wreg%0d", i), wb_wreg[i], m_wreg[i]);
      check($sformatf("m_wd%0d", i), wb_wd[i*AW +: AW], m_wd[i]);
      check($sformatf("m_wdata%0d", i), wb_wdata[i*DW +: DW], m_wdata[i]);
    end
    check("m_whilo", wb_whilo, m_whilo);
    check("m_hi", wb_hi, m_hi);
    check("m_lo", wb_lo, m_lo);
    check("m_llwe", wb_llbit_we, m_llwe);
    check("m_llv", wb_llbit_value, m_llv);
    check("m_cnt", retire_cnt, m_cnt);
    check("m_cnt4", w_retire_cnt, m_cnt % 16);
    check("m_err", ctrl_err, m_err);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    model_compare();
  endtask

  typedef struct {
    logic rst, flush, sm, sw;
    logic [1:0] v, w;
    logic [4:0] wd0, wd1;
    logic [31:0] d0, d1;
    logic whilo;
    logic [31:0] hi, lo;
    logic llwe, llv;
    logic [1:0] e_v, e_w;
    logic [4:0] e_wd0, e_wd1;
    logic [31:0] e_d0, e_d1;
    logic e_whilo;
    logic [31:0] e_cnt;
    logic e_err;
  } vec_t;

  vec_t vecs[15];

  initial begin
    // rst flush sm sw v w wd0 wd1 d0 d1 whilo hi lo llwe llv | e_v e_w e_wd0 e_wd1 e_d0 e_d1 e_whilo e_cnt e_err
    vecs[0]  = '{1,0,0,0,2'b11,2'b11,5'd7,5'd3,32'hB,32'hA,1,32'h1,32'h2,1,1, 2'b00,2'b00,5'd0,5'd0,32'h0,32'h0,0,32'd0,0};
    vecs[1]  = vecs[0];
    vecs[2]  = '{0,0,0,0,2'b11,2'b11,5'd7,5'd3,32'hB,32'hA,0,32'h0,32'h0,0,0, 2'b11,2'b11,5'd7,5'd3,32'hB,32'hA,0,32'd2,0};
    vecs[3]  = '{0,0,0,0,2'b11,2'b11,5'd9,5'd9,32'h11,32'h22,0,32'h0,32'h0,0,0, 2'b11,2'b10,5'd9,5'd9,32'h11,32'h22,0,32'd4,0};
    vecs[4]  = '{0,0,1,1,2'b11,2'b11,5'd1,5'd2,32'h33,32'h44,1,32'h7,32'h8,0,0, 2'b11,2'b10,5'd9,5'd9,32'h11,32'h22,0,32'd4,0};
    vecs[5]  = vecs[4];
    vecs[6]  = vecs[4];
    vecs[7]  = '{0,0,1,0,2'b11,2'b11,5'd1,5'd2,32'h33,32'h44,1,32'h7,32'h8,0,0, 2'b00,2'b00,5'd0,5'd0,32'h0,32'h0,0,32'd4,0};
    vecs[8]  = '{0,0,0,0,2'b01,2'b11,5'd4,5'd6,32'h55,32'h66,1,32'h5,32'h6,0,0, 2'b01,2'b01,5'd4,5'd0,32'h55,32'h0,1,32'd5,0};
    vecs[9]  = '{0,1,1,1,2'b11,2'b11,5'd1,5'd2,32'h33,32'h44,1,32'h5,32'h6,1,1, 2'b00,2'b00,5'd0,5'd0,32'h0,32'h0,0,32'd5,0};
    vecs[10] = '{0,0,0,0,2'b10,2'b11,5'd8,5'd0,32'h88,32'h77,0,32'h0,32'h0,0,0, 2'b10,2'b10,5'd0,5'd0,32'h0,32'h77,0,32'd6,0};
    vecs[11] = '{0,0,0,1,2'b11,2'b11,5'd1,5'd2,32'h33,32'h44,1,32'h9,32'h9,0,0, 2'b10,2'b10,5'd0,5'd0,32'h0,32'h77,0,32'd6,1};
    vecs[12] = '{0,0,0,0,2'b11,2'b01,5'd5,5'd5,32'h99,32'hAA,0,32'h0,32'h0,0,0, 2'b11,2'b01,5'd5,5'd5,32'h99,32'hAA,0,32'd8,1};
    vecs[13] = '{0,0,0,0,2'b00,2'b11,5'd3,5'd3,32'h1,32'h2,1,32'hC,32'hD,1,1, 2'b00,2'b00,5'd0,5'd0,32'h0,32'h0,0,32'd8,1};
    vecs[14] = '{1,0,0,0,2'b11,2'b11,5'd1,5'd2,32'h3,32'h4,1,32'h1,32'h1,1,1, 2'b00,2'b00,5'd0,5'd0,32'h0,32'h0,0,32'd0,0};

    m_cnt = 0; m_err = 0; model_clear_stage();

    for (int k = 0; k < 15; k++) begin
      rst = vecs[k].rst; flush = vecs[k].flush;
      stall_mem = vecs[k].sm; stall_wb = vecs[k].sw;
      mem_valid = vecs[k].v; mem_wreg = vecs[k].w;
      mem_wd = {vecs[k].wd1, vecs[k].wd0};
      mem_wdata = {vecs[k].d1, vecs[k].d0};
      mem_whilo = vecs[k].whilo; mem_hi = vecs[k].hi; mem_lo = vecs[k].lo;
      mem_llbit_we = vecs[k].llwe; mem_llbit_value = vecs[k].llv;
      tick();
      check($sformatf("v%0d_valid", k), wb_valid, vecs[k].e_v);
      check($sformatf("v%0d_wreg", k), wb_wreg, vecs[k].e_w);
      check($sformatf("v%0d_wd0", k), wb_wd[AW-1:0], vecs[k].e_wd0);
      check($sformatf("v%0d_wd1", k), wb_wd[2*AW-1:AW], vecs[k].e_wd1);
      check($sformatf("v%0d_d0", k), wb_wdata[DW-1:0], vecs[k].e_d0);
      check($sformatf("v%0d_d1", k), wb_wdata[2*DW-1:DW], vecs[k].e_d1);
      check($sformatf("v%0d_whilo", k), wb_whilo, vecs[k].e_whilo);
      check($sformatf("v%0d_cnt", k), retire_cnt, vecs[k].e_cnt);
      check($sformatf("v%0d_err", k), ctrl_err, vecs[k].e_err);
    end

    // Counter wrap on the 4-bit instance: 7 dual-lane captures reach 14, the 8th wraps to 0.
    rst = 0; flush = 0; stall_mem = 0; stall_wb = 0;
    mem_valid = 2'b11; mem_wreg = 2'b11; mem_wd = {5'd2, 5'd1};
    mem_whilo = 0; mem_llbit_we = 0;
    for (int n = 1; n <= 8; n++) begin
      mem_wdata = {32'(n), 32'(n + 100)};
      tick();
      if (n == 7) check("wrap_cnt4_14", w_retire_cnt, 4'd14);
      if (n == 8) begin
        check("wrap_cnt4_0", w_retire_cnt, 4'd0);
        check("wrap_cnt32_16", retire_cnt, 32'd16);
      end
    end

    // Randomized traffic; small address range forces frequent same-destination conflicts.
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 49) == 0);
      flush     = ($urandom_range(0, 9) == 0);
      stall_mem = ($urandom_range(0, 3) == 0);
      stall_wb  = ($urandom_range(0, 3) == 0);
      mem_valid = 2'($urandom);
      mem_wreg  = 2'($urandom);
      mem_wd    = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      mem_wdata = {$urandom, $urandom};
      mem_whilo = 1'($urandom); mem_hi = $urandom; mem_lo = $urandom;
      mem_llbit_we = 1'($urandom); mem_llbit_value = 1'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
Parametrised MEM/WB pipeline register for the multi-issue core. It carries LANES independent register-file write requests from MEM to WB, plus HI/LO and LLbit updates. It supports pipeline stall, bubble insertion and flush, and resolves same-destination conflicts between lanes. It also keeps a retired-instruction counter. It sits between the memory-access stage and the register-file/HI-LO/LLbit write ports.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register address width
LANES, 2, parallel write lanes (1..4); a higher lane index is a younger instruction
CNT_W, 32, retired-instruction counter width

Ports:
clk  in  1  clock
rst  in  1  reset
stall_mem  in  1  MEM stage stalled
stall_wb  in  1  WB stage stalled
flush  in  1  exception/branch flush; kill the incoming MEM contents
mem_valid  in  LANES  lane carries a real instruction
mem_wreg  in  LANES  lane writes the register file
mem_wd  in  LANES*ADDR_W  lane destination address, lane i at bits [i*ADDR_W +: ADDR_W]
mem_wdata  in  LANES*DATA_W  lane write data
mem_whilo  in  1  HI/LO write enable (lane-independent)
mem_hi  in  DATA_W  HI value
mem_lo  in  DATA_W  LO value
mem_llbit_we  in  1  LLbit write enable
mem_llbit_value  in  1  LLbit value
wb_valid  out  LANES  registered valid
wb_wreg  out  LANES  registered write enable, after conflict kill
wb_wd  out  LANES*ADDR_W  registered destination
wb_wdata  out  LANES*DATA_W  registered data
wb_whilo  out  1  registered HI/LO enable
wb_hi  out  DATA_W  registered HI value
wb_lo  out  DATA_W  registered LO value
wb_llbit_we  out  1  registered LLbit enable
wb_llbit_value  out  1  registered LLbit value
retire_cnt  out  CNT_W  count of valid lanes captured since reset
ctrl_err  out  1  sticky flag: illegal stall combination seen

Behaviour:
- Reset: rst is synchronous, active-high, on the rising edge of clk. While rst is high, all outputs are 0: wb_wd = 0 (the NOP register), wb_wdata, wb_hi and wb_lo = 0, every enable and valid = 0, retire_cnt = 0, ctrl_err = 0.
- Per-edge priority: rst > flush > stall decode.
  - flush=1: load a bubble. All valid, wreg, whilo and llbit_we go to 0; wb_wd goes to 0; data, hi and lo go to 0. retire_cnt holds.
  - stall_mem=1, stall_wb=0: load a bubble (same as flush).
  - stall_mem=1, stall_wb=1: hold every register unchanged.
  - stall_mem=0, stall_wb=0: capture the MEM inputs.
  - stall_mem=0, stall_wb=1: illegal. Hold all registers and set ctrl_err=1. ctrl_err clears only on rst.
- Capture rules:
  - wb_wreg[i] = mem_valid[i] & mem_wreg[i] & ~killed[i].
  - killed[i] = 1 when any younger lane j>i has mem_valid[j] & mem_wreg[j] and an equal address. The youngest writer wins.
  - A write to address 0 is captured unchanged; it is not filtered.
  - Invalid lanes capture wd=0, wdata=0 and valid=0.
  - HI/LO and LLbit fields capture directly. Their enables are gated by OR of mem_valid; with no valid lane they load 0.
- Latency: exactly 1 cycle MEM→WB. There is no combinational path from inputs to outputs.
- retire_cnt: on a capture edge, add popcount(mem_valid). Use modulo 2^CNT_W wrap-around with no saturation. It does not change on bubble, hold or flush.

Decomposition:
- Shared package (mem_wb_pkg):
  - NOP_REG_ADDR (0) and ZERO_WORD constants.
  - Stage-control enum {CAPTURE, BUBBLE, HOLD, ILLEGAL} with its decode function from (flush, stall_mem, stall_wb).
- Sub-module mem_wb_lane:
  - One lane's valid/wreg/wd/wdata register.
  - Inputs: the stage-control value and a kill bit.
  - Instantiated LANES times via generate.
- Conflict-kill logic and the counter stay in the top level.

Test Plan:
1. Reset then capture (LANES=2): rst high for 2 cycles, then mem_valid=11, mem_wreg=11, wd={5'd3,5'd7}, wdata={32'hA,32'hB}. Expect: all outputs 0 during reset; one cycle later wb_wreg=11 with the same values; retire_cnt=2.
2. Same-destination conflict: both lanes target address 9, data lane0=0x11, lane1=0x22. Expect wb_wreg=10 and lane1 data 0x22. Lane 0's wd and wdata are still captured (9, 0x11) with wreg=0. retire_cnt increments by 2.
3. Stall and bubble: stall_mem=1 with stall_wb=1 for 3 cycles, then stall_wb=0 for 1 cycle. Expect outputs held for 3 cycles, then a bubble (all enables 0). retire_cnt unchanged throughout.
4. Flush over stall: flush=1 together with stall_mem=1, stall_wb=1. Expect a bubble, not a hold. A HI/LO write pending in MEM (whilo=1, hi=0x5, lo=0x6) does not reach WB.
5. Illegal control: stall_mem=0, stall_wb=1. Expect outputs held and ctrl_err=1, staying 1 after the condition clears until the next rst.
6. Counter wrap: CNT_W=4, drive captures with 2 valid lanes. Expect retire_cnt to go 14 → 0 on the 8th capture.
